// File: rtl/baby_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module : baby_wb_pkg
// Shared register map, bit positions, FSM encoding and byte-merge helper.
// Rev    : 1.0
// ============================================================================
package baby_wb_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h3000_0000;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CYCLES = 8'h08;

  localparam int CTRL_RUN_BIT    = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int STAT_STOP_BIT   = 0;
  localparam int STAT_HALTED_BIT = 1;
  localparam int STAT_VIOL_BIT   = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REG_ACK = 3'd1,
    ST_RAM_RD  = 3'd2,
    ST_RAM_CAP = 3'd3,
    ST_RAM_WR  = 3'd4,
    ST_ACK     = 3'd5
  } state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/baby_cycle_counter.sv
`default_nettype none
// ============================================================================
// Module : baby_cycle_counter
// Saturating up-counter; clear has priority over enable.
// Rev    : 1.0
// ============================================================================
module baby_cycle_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/baby_wb_loader.sv
`default_nettype none
// ============================================================================
// Module : baby_wb_loader
// Wishbone window for loading/inspecting the Baby core RAM and run control.
// Rev    : 1.0
// ============================================================================
module baby_wb_loader
  import baby_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        baby_reset_o,
  input  logic        stop_lamp_i,
  output logic        ram_sel_o,
  output logic [4:0]  ram_addr_o,
  output logic [31:0] ram_data_o,
  output logic        ram_we_o,
  input  logic [31:0] ram_data_i,
  output logic        irq_o
);

  state_t      r_state, w_state_nxt;
  logic        w_hit, w_ram_win, w_accept, w_full_wr;
  logic [7:0]  w_off;
  logic        w_reg_wr, w_ctrl_wr, w_stat_wr;
  logic        w_run_nxt, w_halt_set, w_viol_set;
  logic        w_cyc_clr, w_cyc_en;
  logic [31:0] w_cycles, w_reg_rdata;
  logic        w_unused;

  logic        r_run, r_irq_en, r_halted, r_viol, r_stop_q, r_irq;
  logic        r_ram_sel, r_baby_rst;
  logic        r_is_wr;
  logic [3:0]  r_wsel;
  logic [31:0] r_wdata, r_rdata, r_ram_data;
  logic [4:0]  r_ram_addr;

  assign w_unused  = &{1'b0, wbs_adr_i[1:0]};
  assign w_off     = wbs_adr_i[7:0];
  assign w_hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_ram_win = w_off[7];
  assign w_accept  = (r_state == ST_IDLE) & w_hit;
  assign w_full_wr = wbs_we_i & (wbs_sel_i == 4'hF);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // RAM traffic is only routed to the RAM states while the core is stopped.
  always_comb begin
    w_state_nxt = r_state;
    wbs_ack_o   = 1'b0;
    ram_we_o    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_ram_win && !r_run) w_state_nxt = w_full_wr ? ST_RAM_WR : ST_RAM_RD;
          else                     w_state_nxt = ST_REG_ACK;
        end
      end
      ST_RAM_RD:  w_state_nxt = ST_RAM_CAP;
      ST_RAM_CAP: w_state_nxt = r_is_wr ? ST_RAM_WR : ST_ACK;
      ST_RAM_WR: begin
        ram_we_o    = ~r_run;
        w_state_nxt = ST_ACK;
      end
      ST_REG_ACK, ST_ACK: begin
        wbs_ack_o   = wbs_cyc_i;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign wbs_dat_o = wbs_ack_o ? r_rdata : 32'h0;

  always_comb begin
    w_reg_rdata = 32'h0;
    case (w_off)
      OFF_CTRL: begin
        w_reg_rdata[CTRL_RUN_BIT]    = r_run;
        w_reg_rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
      end
      OFF_STATUS: begin
        w_reg_rdata[STAT_STOP_BIT]   = stop_lamp_i;
        w_reg_rdata[STAT_HALTED_BIT] = r_halted;
        w_reg_rdata[STAT_VIOL_BIT]   = r_viol;
      end
      OFF_CYCLES: w_reg_rdata = w_cycles;
      default:    w_reg_rdata = 32'h0;
    endcase
  end

  assign w_reg_wr   = w_accept & wbs_we_i & ~w_ram_win & wbs_sel_i[0];
  assign w_ctrl_wr  = w_reg_wr & (w_off == OFF_CTRL);
  assign w_stat_wr  = w_reg_wr & (w_off == OFF_STATUS);
  assign w_run_nxt  = w_ctrl_wr ? wbs_dat_i[CTRL_RUN_BIT] : r_run;
  assign w_halt_set = r_run & stop_lamp_i & ~r_stop_q;
  assign w_viol_set = w_accept & w_ram_win & r_run;
  assign w_cyc_clr  = w_run_nxt & ~r_run;
  assign w_cyc_en   = r_run & ~stop_lamp_i;

  // Set terms are OR'd after the W1C mask so a same-cycle event wins.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_run      <= 1'b0;
      r_irq_en   <= 1'b0;
      r_halted   <= 1'b0;
      r_viol     <= 1'b0;
      r_stop_q   <= 1'b0;
      r_irq      <= 1'b0;
      r_ram_sel  <= 1'b1;
      r_baby_rst <= 1'b1;
    end else begin
      r_run      <= w_run_nxt;
      if (w_ctrl_wr) r_irq_en <= wbs_dat_i[CTRL_IRQ_EN_BIT];
      r_halted   <= w_halt_set | (r_halted & ~(w_stat_wr & wbs_dat_i[STAT_HALTED_BIT]));
      r_viol     <= w_viol_set | (r_viol & ~(w_stat_wr & wbs_dat_i[STAT_VIOL_BIT]));
      r_stop_q   <= stop_lamp_i;
      r_irq      <= r_halted & r_irq_en;
      r_ram_sel  <= ~w_run_nxt;
      r_baby_rst <= ~w_run_nxt;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_rdata    <= 32'h0;
      r_ram_addr <= 5'd0;
      r_ram_data <= 32'h0;
      r_wdata    <= 32'h0;
      r_wsel     <= 4'h0;
      r_is_wr    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rdata <= 32'h0;
        if (w_ram_win) begin
          if (!r_run) begin
            r_ram_addr <= wbs_adr_i[6:2];
            r_is_wr    <= wbs_we_i;
            r_wdata    <= wbs_dat_i;
            r_wsel     <= wbs_sel_i;
            if (w_full_wr) r_ram_data <= wbs_dat_i;
          end
        end else if (!wbs_we_i) begin
          r_rdata <= w_reg_rdata;
        end
      end
      if (r_state == ST_RAM_CAP) begin
        if (r_is_wr) r_ram_data <= merge_bytes(ram_data_i, r_wdata, r_wsel);
        else         r_rdata    <= ram_data_i;
      end
    end
  end

  baby_cycle_counter #(
    .WIDTH(32)
  ) u_cycles (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .i_clr   (w_cyc_clr),
    .i_en    (w_cyc_en),
    .o_count (w_cycles)
  );

  assign ram_sel_o    = r_ram_sel;
  assign baby_reset_o = r_baby_rst;
  assign ram_addr_o   = r_ram_addr;
  assign ram_data_o   = r_ram_data;
  assign irq_o        = r_irq;

endmodule
`default_nettype wire
